acia_tx: RTL
============

ACIA_TX -- requirements
Module: acia_tx

Interface
REQ-001 SHALL have parameter TICKS_PER_BIT, default 16, 16x-oversample ticks per serial bit.
REQ-002 SHALL have port XTLI  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port BCLK  input  1  baud clock from the baud-rate generator, synchronous to XTLI.
REQ-005 SHALL have port R_SBR  input  4  baud select; 4'b0000 means every XTLI cycle is a tick.
REQ-006 SHALL have port R_WL  input  2  word length: 00=8, 01=7, 10=6, 11=5 bits.
REQ-007 SHALL have port R_SBN  input  1  stop bits: 0=one, 1=two.
REQ-008 SHALL have port R_PME  input  1  parity enable.
REQ-009 SHALL have port R_PMC  input  2  parity mode: 00 odd, 01 even, 10 mark (1), 11 space (0).
REQ-010 SHALL have port TDR_DATA  input  8  transmit data.
REQ-011 SHALL have port TDR_WR  input  1  one-cycle strobe loading TDR_DATA into the transmit data register (TDR).
REQ-012 SHALL have port CTSB  input  1  clear-to-send, active-low.
REQ-013 SHALL have port TXD  output  1  serial out, idle high.
REQ-014 SHALL have port TDRE  output  1  transmit data register empty.
REQ-015 SHALL have port TX_BUSY  output  1  high while a frame is on TXD.

Function
REQ-016 Tick SHALL be a one-cycle pulse on each BCLK rising edge (registered BCLK vs current BCLK), or every cycle when R_SBR=4'b0000.
REQ-017 TDR_WR SHALL load TDR and clear TDRE at the next edge; a write while TDRE=0 overwrites TDR, TDRE stays 0.
REQ-018 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; all transitions occur only on ticks.
REQ-019 From IDLE, on a tick with TDRE=0 and CTSB=0: TDR copied to shift register, TDRE set to 1, state START.
REQ-020 TDR_WR coinciding with the load cycle SHALL win: TDR holds new data, TDRE=0; the shift register takes the old data.
REQ-021 Each state SHALL hold TXD for exactly TICKS_PER_BIT ticks (4-bit tick counter, wraps 15->0 to advance).
REQ-022 START drives 0; DATA drives shift bits LSB first, exactly R_WL-selected count (3-bit index); PARITY only if R_PME=1; STOP drives 1 for one or two bit times per R_SBN.
REQ-023 Parity SHALL be computed over the active data bits only: odd => total ones (data+parity) odd; even => even; mark=1; space=0.
REQ-024 R_WL, R_SBN, R_PME, R_PMC SHALL be captured at frame load; changes mid-frame take effect on the next frame.
REQ-025 At the final STOP tick, if TDRE=0 and CTSB=0 the next frame SHALL load on that same tick (no idle gap); else IDLE.
REQ-026 CTSB going high mid-frame SHALL NOT abort the frame; it only blocks the next load.
REQ-027 TXD SHALL be registered: changes one XTLI cycle after the qualifying tick; TX_BUSY=1 in all states except IDLE.

Reset
REQ-028 RESET=1 SHALL asynchronously force TXD=1, TDRE=1, TX_BUSY=0, state IDLE, TDR=0, shift register, tick counter, bit index and BCLK sample register to 0.
REQ-029 Reset mid-frame SHALL abandon the frame and the pending TDR content; after release the first frame starts only after a new TDR_WR.

Structure
REQ-030 Shared package acia_pkg SHALL hold the FSM state type, R_WL and R_PMC encodings, and TICKS_PER_BIT default.
REQ-031 Tick generation SHALL be sub-module acia_tx_tick (BCLK edge detect plus R_SBR=0000 bypass); the rest stays in acia_tx.

Verification
REQ-032 R_SBR=0000, R_WL=00, R_PME=0, R_SBN=0, write 8'h55 -> TXD: 16 cycles 0, then 1,0,1,0,1,0,1,0 (16 each), 16 cycles 1; TDRE low 1 cycle then high at load.
REQ-033 R_WL=11, R_PME=1, R_PMC=00, write 8'hE3 -> 5 data bits 1,1,0,0,0, parity 1, then stop; frame 8 bit-times.
REQ-034 Two writes (8'hA5, 8'h3C) back-to-back, CTSB=0 -> second START begins on the tick ending the first STOP; TXD never idles between frames.
REQ-035 CTSB=1, write 8'h0F -> TXD stays 1, TDRE stays 0; CTSB->0 -> frame starts on next tick; CTSB->1 mid-DATA -> frame completes.
REQ-036 RESET pulsed during DATA of frame 8'hFF -> TXD=1, TDRE=1, TX_BUSY=0 immediately; no further frame without new TDR_WR.
REQ-037 R_SBR=4'b0111 with generator BCLK, R_SBN=1 -> each bit lasts 16 BCLK rising edges, stop lasts 32.

Source files
------------

// File: rtl/acia_pkg.sv
// acia_pkg: shared FSM state type, format encodings and defaults for the ACIA transmitter
package acia_pkg;
  localparam int TICKS_PER_BIT_DEF = 16;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
  typedef enum logic [1:0] {WL_8 = 2'b00, WL_7 = 2'b01, WL_6 = 2'b10, WL_5 = 2'b11} wl_e;
  typedef enum logic [1:0] {PMC_ODD = 2'b00, PMC_EVEN = 2'b01, PMC_MARK = 2'b10, PMC_SPACE = 2'b11} pmc_e;
  function automatic logic [2:0] last_idx(input logic [1:0] wl);
    return 3'd7 - {1'b0, wl};
  endfunction
  function automatic logic [7:0] data_mask(input logic [1:0] wl);
    return 8'hFF >> wl;
  endfunction
endpackage

// File: rtl/acia_tx_tick.sv
// acia_tx_tick: oversample tick from BCLK rising edges; XTLI clock, RESET async, BCLK in, R_SBR select, tick_o pulse out
module acia_tx_tick (
  input  logic       XTLI,
  input  logic       RESET,
  input  logic       BCLK,
  input  logic [3:0] R_SBR,
  output logic       tick_o
);
  logic bclk_q;
  always_ff @(posedge XTLI or posedge RESET)
    if (RESET) bclk_q <= 1'b0;
    else bclk_q <= BCLK;
  always_comb tick_o = (R_SBR == 4'b0000) | (BCLK & ~bclk_q);
endmodule

// File: rtl/acia_tx.sv
// acia_tx: ACIA serial transmitter; XTLI/RESET clock+async reset, BCLK/R_SBR tick source, R_* frame format, TDR_DATA/TDR_WR write port, CTSB flow control, TXD/TDRE/TX_BUSY status
module acia_tx
  import acia_pkg::*;
#(
  parameter int TICKS_PER_BIT = TICKS_PER_BIT_DEF
) (
  input  logic       XTLI,
  input  logic       RESET,
  input  logic       BCLK,
  input  logic [3:0] R_SBR,
  input  logic [1:0] R_WL,
  input  logic       R_SBN,
  input  logic       R_PME,
  input  logic [1:0] R_PMC,
  input  logic [7:0] TDR_DATA,
  input  logic       TDR_WR,
  input  logic       CTSB,
  output logic       TXD,
  output logic       TDRE,
  output logic       TX_BUSY
);
  localparam logic [3:0] LAST = 4'(TICKS_PER_BIT - 1);
  tx_state_e  state_q, state_d;
  logic [7:0] tdr_q, tdr_d, shr_q, shr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [1:0] wl_q, wl_d, pmc_q, pmc_d;
  logic       tdre_q, tdre_d, sbn_q, sbn_d, pme_q, pme_d, txd_q, txd_d;
  logic       tick, tick_end, stop_done, load, par;
  acia_tx_tick u_tick (
    .XTLI  (XTLI),
    .RESET (RESET),
    .BCLK  (BCLK),
    .R_SBR (R_SBR),
    .tick_o(tick)
  );
  always_ff @(posedge XTLI or posedge RESET)
    if (RESET) begin
      state_q <= IDLE;
      tdr_q   <= '0;
      tdre_q  <= 1'b1;
      shr_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      wl_q    <= '0;
      pmc_q   <= '0;
      sbn_q   <= 1'b0;
      pme_q   <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      tdr_q   <= tdr_d;
      tdre_q  <= tdre_d;
      shr_q   <= shr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wl_q    <= wl_d;
      pmc_q   <= pmc_d;
      sbn_q   <= sbn_d;
      pme_q   <= pme_d;
      txd_q   <= txd_d;
    end
  always_comb begin
    tick_end  = tick & (cnt_q == LAST);
    // idx_q doubles as the stop-bit counter once DATA is done
    stop_done = (state_q == STOP) & tick_end & (~sbn_q | idx_q[0]);
    load      = tick & ~tdre_q & ~CTSB & ((state_q == IDLE) | stop_done);
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shr_d     = shr_q;
    wl_d      = wl_q;
    pmc_d     = pmc_q;
    sbn_d     = sbn_q;
    pme_d     = pme_q;
    if (tick && state_q != IDLE) cnt_d = tick_end ? '0 : cnt_q + 4'd1;
    case (state_q)
      IDLE:    state_d = load ? START : IDLE;
      START:   if (tick_end) begin
        state_d = DATA;
        idx_d   = '0;
      end
      DATA:    if (tick_end) begin
        state_d = (idx_q == last_idx(wl_q)) ? (pme_q ? PARITY : STOP) : DATA;
        idx_d   = (idx_q == last_idx(wl_q)) ? 3'd0 : idx_q + 3'd1;
      end
      PARITY:  if (tick_end) state_d = STOP;
      STOP:    if (tick_end) begin
        state_d = stop_done ? (load ? START : IDLE) : STOP;
        idx_d   = stop_done ? 3'd0 : 3'd1;
      end
      default: state_d = IDLE;
    endcase
    // the shift register takes the old TDR even if a write lands on the load cycle
    if (load) begin
      shr_d = tdr_q;
      wl_d  = R_WL;
      pmc_d = R_PMC;
      sbn_d = R_SBN;
      pme_d = R_PME;
      idx_d = '0;
      cnt_d = '0;
    end
    tdr_d  = TDR_WR ? TDR_DATA : tdr_q;
    tdre_d = TDR_WR ? 1'b0 : (load ? 1'b1 : tdre_q);
    par    = (pmc_q == PMC_MARK) ? 1'b1 : (pmc_q == PMC_SPACE) ? 1'b0 :
             (^(shr_q & data_mask(wl_q))) ^ (pmc_q == PMC_ODD);
    txd_d  = (state_d == START) ? 1'b0 : (state_d == DATA) ? shr_d[idx_d] :
             (state_d == PARITY) ? par : 1'b1;
  end
  always_comb begin
    TXD     = txd_q;
    TDRE    = tdre_q;
    TX_BUSY = state_q != IDLE;
  end
endmodule
